// File: rtl/uart_pic_writer_if.sv
// Byte-in / pixel-out bundle between a UART receiver, the picture writer and the picture RAM.
interface uart_pic_writer_if #(
  parameter int ADDR_WIDTH = 17,
  parameter int DATA_WIDTH = 24
);
  logic [7:0]            rx_data;
  logic                  rx_done;
  logic [ADDR_WIDTH-1:0] uart_addr;
  logic [DATA_WIDTH-1:0] pic_out;
  logic                  wr_ram;
  logic                  pic_done;
  logic                  frame_err;

  modport master (
    output rx_data, rx_done,
    input  uart_addr, pic_out, wr_ram, pic_done, frame_err
  );

  modport slave (
    input  rx_data, rx_done,
    output uart_addr, pic_out, wr_ram, pic_done, frame_err
  );
endinterface

// File: rtl/uart_pic_writer.sv
// Assembles a 0x55,0xAA-headed UART byte stream into {R,G,B} pixels and writes them
// to the picture RAM, aborting the frame if the sender goes quiet for too long.
module uart_pic_writer #(
  parameter int ADDR_WIDTH  = 17,
  parameter int DATA_WIDTH  = 24,
  parameter int PIX_NUM     = 129600,
  parameter int TIMEOUT_CYC = 1000000
) (
  input  logic              clk_100M,
  input  logic              rst_n,
  uart_pic_writer_if.slave  bus
);
  localparam int IDLE_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(PIX_NUM - 1);
  localparam logic [IDLE_W-1:0]     IDLE_LAST = IDLE_W'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {SYNC0, SYNC1, RECV} state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic [1:0]            r_lane;
  logic [7:0]            r_red;
  logic [7:0]            r_green;
  logic [ADDR_WIDTH-1:0] r_pix_cnt;
  logic [ADDR_WIDTH-1:0] r_uart_addr;
  logic [DATA_WIDTH-1:0] r_pic_out;
  logic                  r_wr_ram;
  logic                  r_pic_done;
  logic                  r_frame_err;
  logic [IDLE_W-1:0]     r_idle_cnt;

  logic w_hdr_ok;
  logic w_pix_wr;
  logic w_frame_end;
  logic w_timeout;
  logic w_take_byte;

  always_comb begin
    w_state_next = r_state;
    w_hdr_ok     = 1'b0;
    w_pix_wr     = 1'b0;
    w_frame_end  = 1'b0;
    w_timeout    = 1'b0;
    w_take_byte  = 1'b0;
    case (r_state)
      SYNC0: begin
        if (bus.rx_done && bus.rx_data == 8'h55) w_state_next = SYNC1;
      end
      SYNC1: begin
        if (bus.rx_done) begin
          if (bus.rx_data == 8'hAA) begin
            w_state_next = RECV;
            w_hdr_ok     = 1'b1;
          end else if (bus.rx_data != 8'h55) begin
            w_state_next = SYNC0;
          end
        end
      end
      RECV: begin
        // Frame completes the cycle after the last address is written.
        if (r_wr_ram && r_uart_addr == LAST_ADDR) begin
          w_frame_end  = 1'b1;
          w_state_next = SYNC0;
        end else if (bus.rx_done) begin
          w_take_byte = 1'b1;
          w_pix_wr    = (r_lane == 2'd2);
        end else if (r_idle_cnt == IDLE_LAST) begin
          w_timeout    = 1'b1;
          w_state_next = SYNC0;
        end
      end
      default: w_state_next = SYNC0;
    endcase
  end

  always_ff @(posedge clk_100M or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= SYNC0;
      r_lane      <= 2'd0;
      r_red       <= 8'd0;
      r_green     <= 8'd0;
      r_pix_cnt   <= '0;
      r_uart_addr <= '0;
      r_pic_out   <= '0;
      r_wr_ram    <= 1'b0;
      r_pic_done  <= 1'b0;
      r_frame_err <= 1'b0;
      r_idle_cnt  <= '0;
    end else begin
      r_state     <= w_state_next;
      r_wr_ram    <= w_pix_wr;
      r_frame_err <= w_timeout;

      if (w_hdr_ok) begin
        r_pic_done <= 1'b0;
        r_lane     <= 2'd0;
        r_pix_cnt  <= '0;
      end
      if (w_frame_end) r_pic_done <= 1'b1;
      if (w_timeout)   r_lane     <= 2'd0;

      if (w_take_byte) begin
        r_lane <= (r_lane == 2'd2) ? 2'd0 : r_lane + 2'd1;
        if (r_lane == 2'd0) r_red   <= bus.rx_data;
        if (r_lane == 2'd1) r_green <= bus.rx_data;
      end

      if (w_pix_wr) begin
        r_uart_addr <= r_pix_cnt;
        r_pic_out   <= {r_red, r_green, bus.rx_data};
        if (r_pix_cnt != LAST_ADDR) r_pix_cnt <= r_pix_cnt + 1'b1;
      end

      // Idle timer only runs while a frame is in flight.
      if (r_state == RECV && w_state_next == RECV && !bus.rx_done)
        r_idle_cnt <= r_idle_cnt + 1'b1;
      else
        r_idle_cnt <= '0;
    end
  end

  assign bus.uart_addr = r_uart_addr;
  assign bus.pic_out   = r_pic_out;
  assign bus.wr_ram    = r_wr_ram;
  assign bus.pic_done  = r_pic_done;
  assign bus.frame_err = r_frame_err;
endmodule

// File: tb/tb_uart_pic_writer.sv
// Scoreboard bench for uart_pic_writer: stimulus queues expected RAM writes,
// a negedge monitor pops and compares them and counts frame_err pulses.
module tb_uart_pic_writer;
  localparam int AW = 17;
  localparam int DW = 24;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    int            cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   ferr_seen = 0;
  int   exp_ferr = 0;
  int   last_ferr_cyc = -1;
  int   last_strobe = 0;
  int   s;
  exp_t q[$];

  uart_pic_writer_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  uart_pic_writer #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .PIX_NUM(4), .TIMEOUT_CYC(16)
  ) dut (
    .clk_100M(clk),
    .rst_n   (rst_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every write must match the oldest expected write, including its cycle.
  always @(negedge clk) begin
    exp_t e;
    if (bus.frame_err) begin
      ferr_seen = ferr_seen + 1;
      last_ferr_cyc = cyc;
      $display("frame_err at cycle %0d", cyc);
    end
    if (bus.wr_ram) begin
      checks = checks + 1;
      if (q.size() == 0) begin
        errors = errors + 1;
        $display("FAIL unexpected_write: addr=%0h data=%06h cycle=%0d, required no write",
                 bus.uart_addr, bus.pic_out, cyc);
      end else begin
        e = q.pop_front();
        if (bus.uart_addr !== e.addr || bus.pic_out !== e.data || cyc != e.cyc) begin
          errors = errors + 1;
          $display("FAIL write_check: addr=%0h data=%06h cycle=%0d, required addr=%0h data=%06h cycle=%0d",
                   bus.uart_addr, bus.pic_out, cyc, e.addr, e.data, e.cyc);
        end else begin
          $display("write addr=%0h data=%06h cycle=%0d ok", bus.uart_addr, bus.pic_out, cyc);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks = checks + 1;
    if (act !== req) begin
      errors = errors + 1;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap, input bit wr,
                           input logic [AW-1:0] a, input logic [DW-1:0] d);
    exp_t e;
    @(posedge clk); #1;
    bus.rx_data = b;
    bus.rx_done = 1'b1;
    last_strobe = cyc;
    if (wr) begin
      e.addr = a; e.data = d; e.cyc = cyc + 1;
      q.push_back(e);
    end
    $display("tx byte %02h at cycle %0d", b, cyc);
    @(posedge clk); #1;
    bus.rx_done = 1'b0;
    repeat (gap - 2) @(posedge clk);
    #1;
  endtask

  task automatic tx(input logic [7:0] b);
    send_byte(b, 2, 1'b0, '0, '0);
  endtask

  task automatic send_pix(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                          input logic [AW-1:0] a);
    tx(r);
    tx(g);
    send_byte(b, 2, 1'b1, a, {r, g, b});
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_addr"},  32'(bus.uart_addr), 32'd0);
    chk({tag, "_pic"},   32'(bus.pic_out),   32'd0);
    chk({tag, "_wr"},    32'(bus.wr_ram),    32'd0);
    chk({tag, "_done"},  32'(bus.pic_done),  32'd0);
    chk({tag, "_ferr"},  32'(bus.frame_err), 32'd0);
  endtask

  initial begin
    bus.rx_data = 8'h00;
    bus.rx_done = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_outputs_zero("reset");
    rst_n = 1'b1;

    // Single pixel, then timeout on a frame left open.
    tx(8'h55); tx(8'hAA);
    send_pix(8'h11, 8'h22, 8'h33, 17'd0);
    s = last_strobe;
    exp_ferr = exp_ferr + 1;
    repeat (25) @(posedge clk); #1;
    chk("t2_queue_empty", 32'(q.size()), 32'd0);
    chk("t2_ferr_count", 32'(ferr_seen), 32'(exp_ferr));
    chk("t2_ferr_cycle", 32'(last_ferr_cyc), 32'(s + 17));
    chk("t2_pic_done", 32'(bus.pic_done), 32'd0);

    // Repeated 0x55 before 0xAA, full frame, header bytes used as pixel data.
    tx(8'h55); tx(8'h55); tx(8'hAA);
    send_pix(8'h01, 8'h02, 8'h03, 17'd0);
    send_pix(8'h55, 8'hAA, 8'h55, 17'd1);
    send_pix(8'h07, 8'h08, 8'h09, 17'd2);
    send_pix(8'h0A, 8'h0B, 8'h0C, 17'd3);
    chk("t3_last_wr", 32'(bus.wr_ram), 32'd1);
    chk("t3_done_during_wr", 32'(bus.pic_done), 32'd0);
    @(posedge clk); #1;
    chk("t3_done_after_wr", 32'(bus.pic_done), 32'd1);
    tx(8'h00);
    repeat (4) @(posedge clk); #1;
    chk("t3_queue_empty", 32'(q.size()), 32'd0);
    chk("t3_done_held", 32'(bus.pic_done), 32'd1);

    // Broken header: must not enter RECV.
    tx(8'h55); tx(8'h12); tx(8'hAA);
    tx(8'h01); tx(8'h02); tx(8'h03);
    repeat (4) @(posedge clk); #1;
    chk("t4_done_held", 32'(bus.pic_done), 32'd1);
    chk("t4_ferr_count", 32'(ferr_seen), 32'(exp_ferr));

    // New header clears pic_done; partial pixel then timeout.
    tx(8'h55);
    chk("t5_done_before_aa", 32'(bus.pic_done), 32'd1);
    tx(8'hAA);
    chk("t5_done_after_aa", 32'(bus.pic_done), 32'd0);
    tx(8'h01); tx(8'h02);
    s = last_strobe;
    exp_ferr = exp_ferr + 1;
    repeat (20) @(posedge clk); #1;
    chk("t5_ferr_count", 32'(ferr_seen), 32'(exp_ferr));
    chk("t5_ferr_cycle", 32'(last_ferr_cyc), 32'(s + 17));
    chk("t5_pic_done", 32'(bus.pic_done), 32'd0);
    tx(8'h55); tx(8'hAA);
    send_pix(8'hA1, 8'hB2, 8'hC3, 17'd0);

    // Bytes landing exactly on the timeout cycle are taken.
    send_byte(8'hD1, 16, 1'b0, '0, '0);
    send_byte(8'hE2, 16, 1'b0, '0, '0);
    send_byte(8'hF3, 2, 1'b1, 17'd1, 24'hD1E2F3);
    repeat (5) @(posedge clk); #1;
    chk("t5_coincide_no_ferr", 32'(ferr_seen), 32'(exp_ferr));
    chk("t5_coincide_queue", 32'(q.size()), 32'd0);

    // Reset mid-frame.
    tx(8'h01); tx(8'h02);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk_outputs_zero("midrst");
    repeat (2) @(posedge clk); #1;
    rst_n = 1'b1;
    tx(8'h03); tx(8'h04); tx(8'h05); tx(8'h06); tx(8'h07); tx(8'h08);
    repeat (3) @(posedge clk); #1;
    chk("t6_no_write_queue", 32'(q.size()), 32'd0);
    tx(8'h55); tx(8'hAA);
    send_pix(8'h5A, 8'h6B, 8'h7C, 17'd0);
    repeat (5) @(posedge clk); #1;
    chk("final_queue_empty", 32'(q.size()), 32'd0);
    chk("final_ferr_count", 32'(ferr_seen), 32'(exp_ferr));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
